icache_refill_ctrl: RTL

The refill controller sits between the instruction-cache miss port and the line-granular memory model. It queues up to two miss requests and issues them one at a time on a single-outstanding valid/ready memory port. It waits for each line with a timeout guard and returns the 128-bit line (or an error) to the cache with backpressure. Flushes from the front end are honoured without corrupting an in-flight memory transaction.

---
 rtl/icache_refill_ctrl_pkg.sv | 20 ++
 rtl/refill_req_fifo.sv | 80 ++++++++
 rtl/icache_refill_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/icache_refill_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : icache_refill_ctrl_pkg
// Summary : Shared state encoding and line geometry for the I-cache refill path
// Revision: 1.0
// ============================================================================
package icache_refill_ctrl_pkg;

    localparam int unsigned DEF_LINE_SIZE = 128;
    localparam int unsigned LINE_OFF_BITS = $clog2(DEF_LINE_SIZE / 8);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } refill_state_t;

endpackage : icache_refill_ctrl_pkg
`default_nettype wire

// File: rtl/refill_req_fifo.sv
`default_nettype none
// ============================================================================
// Module  : refill_req_fifo
// Summary : Two-entry miss-address FIFO with push, pop and single-edge flush
// Revision: 1.0
// ============================================================================
module refill_req_fifo #(
    parameter int unsigned WIDTH = 40
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             w_do_push;
    logic             w_do_pop;

    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign head_o  = mem_q[rd_ptr_q];

    // Flush wins over any push/pop presented in the same cycle.
    assign w_do_push = push_i && !full_o && !flush_i;
    assign w_do_pop  = pop_i && !empty_o && !flush_i;

    always_comb begin
        mem_d[0] = mem_q[0];
        mem_d[1] = mem_q[1];
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (w_do_push) begin
                mem_d[wr_ptr_q] = data_i;
                wr_ptr_d        = ~wr_ptr_q;
            end
            if (w_do_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q[0] <= mem_d[0];
            mem_q[1] <= mem_d[1];
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule : refill_req_fifo
`default_nettype wire

// File: rtl/icache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : icache_refill_ctrl
// Summary : Queues I-cache misses, refills lines over a single-outstanding
//           memory port with a timeout guard, and returns them with backpressure
// Revision: 1.0
// ============================================================================
module icache_refill_ctrl
    import icache_refill_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_SIZE = 40,
    parameter int unsigned LINE_SIZE = 128,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic [ADDR_SIZE-1:0] req_addr_i,
    input  logic                 flush_i,
    output logic                 resp_valid_o,
    input  logic                 resp_ready_i,
    output logic [ADDR_SIZE-1:0] resp_addr_o,
    output logic [LINE_SIZE-1:0] resp_line_o,
    output logic                 resp_error_o,
    output logic                 mem_valid_o,
    output logic [ADDR_SIZE-1:0] mem_addr_o,
    input  logic                 mem_ready_i,
    input  logic [LINE_SIZE-1:0] mem_line_i
);

    localparam int unsigned          CNT_W     = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [ADDR_SIZE-1:0] LINE_MASK = ADDR_SIZE'((1 << LINE_OFF_BITS) - 1);

    refill_state_t          state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   discard_q, discard_d;
    logic [ADDR_SIZE-1:0]   mem_addr_q, mem_addr_d;
    logic [ADDR_SIZE-1:0]   resp_addr_q, resp_addr_d;
    logic [LINE_SIZE-1:0]   resp_line_q, resp_line_d;
    logic                   resp_err_q, resp_err_d;

    logic [ADDR_SIZE-1:0]   w_req_aligned;
    logic [ADDR_SIZE-1:0]   w_fifo_head;
    logic                   w_fifo_full;
    logic                   w_fifo_empty;
    logic                   w_fifo_push;
    logic                   w_fifo_pop;
    logic                   w_capture;
    logic                   w_timeout;

    assign w_req_aligned = req_addr_i & ~LINE_MASK;
    assign req_ready_o   = !w_fifo_full && !flush_i;
    assign w_fifo_push   = req_valid_i && req_ready_o;

    refill_req_fifo #(
        .WIDTH (ADDR_SIZE)
    ) u_req_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_fifo_push),
        .data_i  (w_req_aligned),
        .pop_i   (w_fifo_pop),
        .flush_i (flush_i),
        .head_o  (w_fifo_head),
        .full_o  (w_fifo_full),
        .empty_o (w_fifo_empty)
    );

    // The first WAIT cycle (cnt_q == 0) deliberately ignores mem_ready_i.
    assign w_capture = (state_q == WAIT) && (cnt_q != '0) && mem_ready_i;
    assign w_timeout = (state_q == WAIT) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        discard_d   = discard_q;
        mem_addr_d  = mem_addr_q;
        resp_addr_d = resp_addr_q;
        resp_line_d = resp_line_q;
        resp_err_d  = resp_err_q;
        w_fifo_pop  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!w_fifo_empty && mem_ready_i && !flush_i) begin
                    state_d    = ISSUE;
                    mem_addr_d = w_fifo_head;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = '0;
                if (flush_i) begin
                    discard_d = 1'b1;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (flush_i) begin
                    discard_d = 1'b1;
                end
                if (w_capture || w_timeout) begin
                    cnt_d     = '0;
                    discard_d = 1'b0;
                    // A flushed FIFO no longer holds this entry; popping would drop a newer miss.
                    if (discard_q || flush_i) begin
                        state_d = IDLE;
                    end else begin
                        w_fifo_pop  = 1'b1;
                        resp_addr_d = mem_addr_q;
                        resp_line_d = w_capture ? mem_line_i : '0;
                        resp_err_d  = !w_capture;
                        state_d     = RESP;
                    end
                end
            end
            RESP: begin
                if (flush_i || resp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            discard_q   <= 1'b0;
            mem_addr_q  <= '0;
            resp_addr_q <= '0;
            resp_line_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            discard_q   <= discard_d;
            mem_addr_q  <= mem_addr_d;
            resp_addr_q <= resp_addr_d;
            resp_line_q <= resp_line_d;
            resp_err_q  <= resp_err_d;
        end
    end

    assign mem_valid_o  = (state_q == ISSUE);
    assign mem_addr_o   = mem_addr_q;
    assign resp_valid_o = (state_q == RESP);
    assign resp_addr_o  = resp_addr_q;
    assign resp_line_o  = resp_line_q;
    assign resp_error_o = resp_err_q;

endmodule : icache_refill_ctrl
`default_nettype wire
